// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared states, gate bit indices and vector count for the gate checker
package gate_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int NUM_GATES   = 7;
  localparam int NUM_VECTORS = 4;

  // Bit positions of each gate inside fail_vec and the expected/observed vectors
  localparam int FV_AND   = 0;
  localparam int FV_OR    = 1;
  localparam int FV_XOR   = 2;
  localparam int FV_NAND  = 3;
  localparam int FV_NOR   = 4;
  localparam int FV_XNOR  = 5;
  localparam int FV_NOT_A = 6;

  localparam logic [1:0] LAST_VEC  = 2'(NUM_VECTORS - 1);
  localparam logic [2:0] ERR_LIMIT = 3'(NUM_VECTORS);

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// rtl/gate_truth_table_checker_if.sv - stimulus/response bus between checker and gate block
interface gate_truth_table_checker_if;
  logic A;
  logic B;
  logic AND_Y;
  logic OR_Y;
  logic XOR_Y;
  logic NAND_Y;
  logic NOR_Y;
  logic XNOR_Y;
  logic NOT_A;

  // Checker side: drives A/B, reads the gate results
  modport master (
    output A, B,
    input  AND_Y, OR_Y, XOR_Y, NAND_Y, NOR_Y, XNOR_Y, NOT_A
  );

  // Gate block side: reads A/B, produces results
  modport slave (
    input  A, B,
    output AND_Y, OR_Y, XOR_Y, NAND_Y, NOR_Y, XNOR_Y, NOT_A
  );
endinterface

// File: rtl/gate_expected.sv
// rtl/gate_expected.sv - golden gate results for a given A/B pair
module gate_expected
  import gate_check_pkg::*;
(
  input  logic                 A,
  input  logic                 B,
  output logic [NUM_GATES-1:0] expected
);

  // Reference truth table, one bit per gate at its fail_vec position
  always_comb begin
    expected           = '0;
    expected[FV_AND]   = A & B;
    expected[FV_OR]    = A | B;
    expected[FV_XOR]   = A ^ B;
    expected[FV_NAND]  = ~(A & B);
    expected[FV_NOR]   = ~(A | B);
    expected[FV_XNOR]  = ~(A ^ B);
    expected[FV_NOT_A] = ~A;
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - walks A/B through 00..11 and checks seven gate outputs
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  gate_truth_table_checker_if.master   gif,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [NUM_GATES-1:0]         fail_vec,
  output logic [2:0]                   err_count,
  output logic [1:0]                   vec_idx
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [3:0]           settle_cnt;
  logic                 a_q;
  logic                 b_q;
  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] observed;
  logic [NUM_GATES-1:0] mismatch;
  logic [1:0]           next_idx;

  assign gif.A    = a_q;
  assign gif.B    = b_q;
  assign next_idx = vec_idx + 2'd1;

  gate_expected u_expected (
    .A        (a_q),
    .B        (b_q),
    .expected (expected)
  );

  // Gather the gate results into fail_vec bit order and flag differences
  always_comb begin
    observed           = '0;
    observed[FV_AND]   = gif.AND_Y;
    observed[FV_OR]    = gif.OR_Y;
    observed[FV_XOR]   = gif.XOR_Y;
    observed[FV_NAND]  = gif.NAND_Y;
    observed[FV_NOR]   = gif.NOR_Y;
    observed[FV_XNOR]  = gif.XNOR_Y;
    observed[FV_NOT_A] = gif.NOT_A;
    mismatch           = observed ^ expected;
  end

  // Run sequencer: A/B are loaded on entry to DRIVE so they stay put through CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= '0;
      err_count  <= '0;
      vec_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_DRIVE;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
            vec_idx   <= 2'd0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          fail_vec <= fail_vec | mismatch;
          if ((|mismatch) && (err_count < ERR_LIMIT)) begin
            err_count <= err_count + 3'd1;
          end
          if (vec_idx == LAST_VEC) begin
            // pass and done appear together so pass already covers the final vector
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= ((fail_vec | mismatch) == '0);
          end else begin
            vec_idx <= next_idx;
            a_q     <= next_idx[1];
            b_q     <= next_idx[0];
            state   <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb/tb_gate_truth_table_checker.sv - scoreboard bench for gate_truth_table_checker
module tb_gate_truth_table_checker;

  typedef struct {
    logic [6:0] fv;
    logic [2:0] err;
    logic       pass;
  } res_t;

  logic clk;
  logic rst;
  logic start;
  int   fault;
  int   total;
  int   bad;

  logic [1:0] vec_q[$];
  res_t       res_q[$];

  logic       busy, done, pass;
  logic [6:0] fail_vec;
  logic [2:0] err_count;
  logic [1:0] vec_idx;

  logic       busy1, done1, pass1;
  logic [6:0] fail_vec1;
  logic [2:0] err_count1;
  logic [1:0] vec_idx1;

  logic       busy15, done15, pass15;
  logic [6:0] fail_vec15;
  logic [2:0] err_count15;
  logic [1:0] vec_idx15;

  gate_truth_table_checker_if gif ();
  gate_truth_table_checker_if gif1 ();
  gate_truth_table_checker_if gif15 ();

  // Gate block under test for the main instance, with selectable faults
  assign gif.AND_Y  = (fault == 1) ? 1'b0 : (gif.A & gif.B);
  assign gif.OR_Y   = gif.A | gif.B;
  assign gif.XOR_Y  = gif.A ^ gif.B;
  assign gif.NAND_Y = ~(gif.A & gif.B);
  assign gif.NOR_Y  = ~(gif.A | gif.B);
  assign gif.XNOR_Y = ~(gif.A ^ gif.B);
  assign gif.NOT_A  = (fault == 2) ? gif.A : ~gif.A;

  assign gif1.AND_Y  = gif1.A & gif1.B;
  assign gif1.OR_Y   = gif1.A | gif1.B;
  assign gif1.XOR_Y  = gif1.A ^ gif1.B;
  assign gif1.NAND_Y = ~(gif1.A & gif1.B);
  assign gif1.NOR_Y  = ~(gif1.A | gif1.B);
  assign gif1.XNOR_Y = ~(gif1.A ^ gif1.B);
  assign gif1.NOT_A  = ~gif1.A;

  assign gif15.AND_Y  = gif15.A & gif15.B;
  assign gif15.OR_Y   = gif15.A | gif15.B;
  assign gif15.XOR_Y  = gif15.A ^ gif15.B;
  assign gif15.NAND_Y = ~(gif15.A & gif15.B);
  assign gif15.NOR_Y  = ~(gif15.A | gif15.B);
  assign gif15.XNOR_Y = ~(gif15.A ^ gif15.B);
  assign gif15.NOT_A  = ~gif15.A;

  gate_truth_table_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .gif(gif),
    .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec),
    .err_count(err_count), .vec_idx(vec_idx)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .gif(gif1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fail_vec1),
    .err_count(err_count1), .vec_idx(vec_idx1)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .start(start), .gif(gif15),
    .busy(busy15), .done(done15), .pass(pass15), .fail_vec(fail_vec15),
    .err_count(err_count15), .vec_idx(vec_idx15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    #1;
    total++;
    if ({gif.A, gif.B, busy, done, pass, fail_vec, err_count, vec_idx} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0000",
               {gif.A, gif.B, busy, done, pass, fail_vec, err_count, vec_idx});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One full run on the main instance; expectations queued before start is driven
  task automatic run_main(input string name, input logic [6:0] exp_fv,
                          input logic [2:0] exp_err, input logic exp_pass, input bit inject);
    res_t       r;
    logic [1:0] v;
    bit         seen;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) vec_q.push_back(2'(k));
    res_q.push_back('{exp_fv, exp_err, exp_pass});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      start = (inject && (cyc == 5 || cyc == 16)) ? 1'b1 : 1'b0;
      tick();
      if (cyc == 1) begin
        total++;
        if ({busy, fail_vec, err_count} !== 11'b1_0000000_000) begin
          bad++;
          $display("FAIL %s start_clear got=%b want=10000000000", name, {busy, fail_vec, err_count});
        end
      end
      if ((cyc % 4) == 1 && vec_q.size() > 0) begin
        v = vec_q.pop_front();
        total++;
        if ({gif.A, gif.B, vec_idx} !== {v, v}) begin
          bad++;
          $display("FAIL %s vector got=%b want=%b", name, {gif.A, gif.B, vec_idx}, {v, v});
        end
      end
      if (done) begin
        seen = 1'b1;
        r = res_q.pop_front();
        total++;
        if (cyc != 16) begin
          bad++;
          $display("FAIL %s done_edge got=%0d want=16", name, cyc);
        end
        total++;
        if ({fail_vec, err_count, pass} !== {r.fv, r.err, r.pass}) begin
          bad++;
          $display("FAIL %s result got=%b want=%b", name, {fail_vec, err_count, pass},
                   {r.fv, r.err, r.pass});
        end
      end
    end
    start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done_timeout got=none want=done", name);
      vec_q.delete();
      res_q.delete();
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      total++;
      if ({done, busy, gif.A, gif.B, pass} !== {2'b00, 2'b11, exp_pass}) begin
        bad++;
        $display("FAIL %s idle_after got=%b want=%b", name, {done, busy, gif.A, gif.B, pass},
                 {4'b0011, exp_pass});
      end
    end
  endtask

  task automatic test_pass();
    fault = 0;
    run_main("pass", 7'b0000000, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_and_fault();
    fault = 1;
    run_main("and_fault", 7'b0000001, 3'd1, 1'b0, 1'b0);
    fault = 0;
  endtask

  task automatic test_not_fault();
    fault = 2;
    run_main("not_fault", 7'b1000000, 3'd4, 1'b0, 1'b0);
    fault = 0;
  endtask

  task automatic test_ignore_start();
    fault = 1;
    run_main("ignore_start", 7'b0000001, 3'd1, 1'b0, 1'b1);
    fault = 0;
    run_main("rerun_clean", 7'b0000000, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    first_done = 0;
    second_done = 0;
    start = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 50 && second_done == 0; cyc++) begin
      tick();
      if (done) begin
        if (first_done == 0) first_done = cyc;
        else second_done = cyc;
      end
    end
    start = 1'b0;
    total++;
    if (first_done != 16 || second_done != 34) begin
      bad++;
      $display("FAIL back_to_back got=%0d,%0d want=16,34", first_done, second_done);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) tick();
    total++;
    if ({busy, gif.B, vec_idx} !== 4'b1101) begin
      bad++;
      $display("FAIL reset_mid_pre got=%b want=1101", {busy, gif.B, vec_idx});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({gif.A, gif.B, busy, done, pass, fail_vec, err_count, vec_idx} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=0000",
               {gif.A, gif.B, busy, done, pass, fail_vec, err_count, vec_idx});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL reset_mid_no_done got=activity want=quiet");
    end
    run_main("after_reset", 7'b0000000, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_settle_param();
    int d_main;
    int d1;
    int d15;
    d_main = 0;
    d1 = 0;
    d15 = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 80 && d15 == 0; cyc++) begin
      tick();
      if (done && d_main == 0) d_main = cyc;
      if (done1 && d1 == 0) d1 = cyc;
      if (done15 && d15 == 0) d15 = cyc;
    end
    total++;
    if (d1 != 12) begin
      bad++;
      $display("FAIL settle1_done got=%0d want=12", d1);
    end
    total++;
    if (d15 != 68) begin
      bad++;
      $display("FAIL settle15_done got=%0d want=68", d15);
    end
    total++;
    if (d_main != 16) begin
      bad++;
      $display("FAIL settle2_done got=%0d want=16", d_main);
    end
    total++;
    if ({pass1, pass15} !== 2'b11) begin
      bad++;
      $display("FAIL settle_pass got=%b want=11", {pass1, pass15});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    fault = 0;
    start = 1'b0;
    rst = 1'b1;
    test_reset();
    test_pass();
    test_and_fault();
    test_not_fault();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_settle_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
